// File: rtl/mem_access_pkg.sv
// Shared types for the memory access unit.
//   state_t   : issue FSM state encoding
//   req_width : width of one packed request record (store flag, address, data, tag)
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic int unsigned req_width(input int unsigned aw,
                                              input int unsigned dw,
                                              input int unsigned tw);
        return 1 + aw + dw + tw;
    endfunction

endpackage

// File: rtl/mem_access_unit_req_fifo.sv
// Request FIFO for the memory access unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write wr_data (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   ready      : registered "count below DEPTH"; low while in reset
//   empty_c    : FIFO holds no entries
//   head_c     : oldest entry
module req_fifo #(
    parameter int unsigned WIDTH = 73,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic             ready,
    output logic             empty_c,
    output logic [WIDTH-1:0] head_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count;
    logic [PW-1:0]    count_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full_c;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra bit: equal low bits with differing MSB means full.
    assign empty_c    = (wr_ptr == rd_ptr);
    assign full_c     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push    = push && !full_c;
    assign do_pop     = pop && !empty_c;
    assign head_c     = mem[rd_ptr[AW-1:0]];
    assign count_next = count + PW'(do_push) - PW'(do_pop);

    // Pointer/count state; ready looks ahead so a pop while full only reopens next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
            ready <= (count_next < PW'(DEPTH));
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mem_access_unit.sv
// In-order memory access unit in front of the cache.
// Buffers tagged load/store tokens, issues one at a time to the cache RECEIVE
// port, waits for the SEND reply and returns it with the original tag.
//   ACLK, ARESETN      : clock, asynchronous active-low reset
//   REQ_*              : request token input (valid/ready)
//   RES_*              : result output (valid/ready)
//   CACHE_ADDR/DATA_*  : request to cache; CACHE_DATA_VALID marks a store
//   CACHE_SEND_*       : reply from cache
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  REQ_VALID,
    input  logic                  REQ_STORE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_DATA,
    input  logic [TAG_WIDTH-1:0]  REQ_TAG,
    output logic                  REQ_READY,
    output logic                  RES_VALID,
    output logic [DATA_WIDTH-1:0] RES_DATA,
    output logic [TAG_WIDTH-1:0]  RES_TAG,
    input  logic                  RES_READY,
    output logic                  CACHE_ADDR_VALID,
    output logic [ADDR_WIDTH-1:0] CACHE_ADDR,
    output logic                  CACHE_DATA_VALID,
    output logic [DATA_WIDTH-1:0] CACHE_DATA,
    input  logic                  CACHE_READY,
    input  logic                  CACHE_SEND_VALID,
    input  logic [DATA_WIDTH-1:0] CACHE_SEND_DATA,
    output logic                  CACHE_SEND_READY
);

    localparam int unsigned REQ_W = req_width(ADDR_WIDTH, DATA_WIDTH, TAG_WIDTH);

    typedef struct packed {
        logic                  store;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
    } req_t;

    state_t               state;
    state_t               state_next;
    logic                 pop_c;
    logic                 push_c;
    logic                 empty_c;
    logic [REQ_W-1:0]     head_bits;
    req_t                 wr_req;
    req_t                 head;
    logic [TAG_WIDTH-1:0] iss_tag;

    assign push_c = REQ_VALID && REQ_READY;
    assign wr_req = '{store: REQ_STORE, addr: REQ_ADDR, data: REQ_DATA, tag: REQ_TAG};
    assign head   = req_t'(head_bits);

    req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .push    (push_c),
        .wr_data (wr_req),
        .pop     (pop_c),
        .ready   (REQ_READY),
        .empty_c (empty_c),
        .head_c  (head_bits)
    );

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_next;
    end

    // Next state and FIFO pop; RESP chains straight into ISSUE when work is queued.
    always_comb begin
        state_next = state;
        pop_c      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_c) begin
                    pop_c      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (CACHE_READY) state_next = WAIT;
            end
            WAIT: begin
                if (CACHE_SEND_VALID) state_next = RESP;
            end
            RESP: begin
                if (RES_READY) begin
                    if (!empty_c) begin
                        pop_c      = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs: valids/readies follow the next state, payloads load on pop/capture.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            CACHE_ADDR_VALID <= 1'b0;
            CACHE_DATA_VALID <= 1'b0;
            CACHE_ADDR       <= '0;
            CACHE_DATA       <= '0;
            CACHE_SEND_READY <= 1'b0;
            RES_VALID        <= 1'b0;
            RES_DATA         <= '0;
            RES_TAG          <= '0;
            iss_tag          <= '0;
        end else begin
            CACHE_ADDR_VALID <= (state_next == ISSUE);
            CACHE_SEND_READY <= (state_next == WAIT);
            RES_VALID        <= (state_next == RESP);
            if (pop_c) begin
                CACHE_ADDR       <= head.addr;
                CACHE_DATA       <= head.data;
                CACHE_DATA_VALID <= head.store;
                iss_tag          <= head.tag;
            end else if (state == ISSUE && CACHE_READY) begin
                CACHE_DATA_VALID <= 1'b0;
            end
            if (state == WAIT && CACHE_SEND_VALID) begin
                RES_DATA <= CACHE_SEND_DATA;
                RES_TAG  <= iss_tag;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus a short
// random load/store run against a behavioural cache model.
module tb_mem_access_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 8;

    logic          ACLK;
    logic          ARESETN;
    logic          REQ_VALID;
    logic          REQ_STORE;
    logic [AW-1:0] REQ_ADDR;
    logic [DW-1:0] REQ_DATA;
    logic [TW-1:0] REQ_TAG;
    logic          REQ_READY;
    logic          RES_VALID;
    logic [DW-1:0] RES_DATA;
    logic [TW-1:0] RES_TAG;
    logic          RES_READY;
    logic          CACHE_ADDR_VALID;
    logic [AW-1:0] CACHE_ADDR;
    logic          CACHE_DATA_VALID;
    logic [DW-1:0] CACHE_DATA;
    logic          CACHE_READY;
    logic          CACHE_SEND_VALID;
    logic [DW-1:0] CACHE_SEND_DATA;
    logic          CACHE_SEND_READY;

    mem_access_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW),
        .FIFO_DEPTH (4)
    ) dut (
        .ACLK             (ACLK),
        .ARESETN          (ARESETN),
        .REQ_VALID        (REQ_VALID),
        .REQ_STORE        (REQ_STORE),
        .REQ_ADDR         (REQ_ADDR),
        .REQ_DATA         (REQ_DATA),
        .REQ_TAG          (REQ_TAG),
        .REQ_READY        (REQ_READY),
        .RES_VALID        (RES_VALID),
        .RES_DATA         (RES_DATA),
        .RES_TAG          (RES_TAG),
        .RES_READY        (RES_READY),
        .CACHE_ADDR_VALID (CACHE_ADDR_VALID),
        .CACHE_ADDR       (CACHE_ADDR),
        .CACHE_DATA_VALID (CACHE_DATA_VALID),
        .CACHE_DATA       (CACHE_DATA),
        .CACHE_READY      (CACHE_READY),
        .CACHE_SEND_VALID (CACHE_SEND_VALID),
        .CACHE_SEND_DATA  (CACHE_SEND_DATA),
        .CACHE_SEND_READY (CACHE_SEND_READY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks;
    int errors;
    int nres;

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] data;
    } res_t;

    res_t        exp_q[$];
    logic [31:0] mdl_mem [256];
    logic [31:0] cmem    [256];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Cache model: handshakes are decided at the negedge before the edge that performs them.
    logic        addr_hs, send_hs, busy, lat_store, cache_hold;
    logic [31:0] lat_addr, lat_data, reply;
    int          cnt, lat;

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            addr_hs          = 1'b0;
            send_hs          = 1'b0;
            busy             = 1'b0;
            cnt              = 0;
            CACHE_READY      = 1'b0;
            CACHE_SEND_VALID = 1'b0;
            CACHE_SEND_DATA  = '0;
        end else begin
            if (send_hs) begin
                chk("res_latency", 64'(RES_VALID), 64'(1));
                CACHE_SEND_VALID = 1'b0;
                busy             = 1'b0;
            end
            if (addr_hs) begin
                if (lat_store) begin
                    cmem[lat_addr[9:2]] = lat_data;
                    reply               = lat_data;
                end else begin
                    reply = cmem[lat_addr[9:2]];
                end
                busy = 1'b1;
                cnt  = lat;
            end
            if (busy && !CACHE_SEND_VALID) begin
                if (cnt == 0) begin
                    CACHE_SEND_VALID = 1'b1;
                    CACHE_SEND_DATA  = reply;
                end else begin
                    cnt--;
                end
            end
            CACHE_READY = !cache_hold;
            addr_hs     = CACHE_ADDR_VALID && CACHE_READY;
            if (addr_hs) begin
                lat_addr  = CACHE_ADDR;
                lat_data  = CACHE_DATA;
                lat_store = CACHE_DATA_VALID;
            end
            send_hs = CACHE_SEND_VALID && CACHE_SEND_READY;
        end
    end

    // Result collector, checks each accepted result against the in-order expectation queue.
    logic res_hold;
    logic rand_bp;
    res_t got_exp;

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            RES_READY = 1'b0;
        end else begin
            RES_READY = !res_hold && (!rand_bp || ($urandom_range(0, 3) != 0));
            if (RES_VALID && RES_READY) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_res", 64'(1), 64'(0));
                end else begin
                    got_exp = exp_q.pop_front();
                    chk("res_tag", 64'(RES_TAG), 64'(got_exp.tag));
                    chk("res_data", 64'(RES_DATA), 64'(got_exp.data));
                    nres++;
                end
            end
        end
    end

    // Offer one request from a negedge; returns one negedge after the accepting edge.
    task automatic push(input logic st, input logic [31:0] a, input logic [31:0] d,
                        input logic [7:0] t, output bit ok);
        res_t e;
        REQ_VALID = 1'b1;
        REQ_STORE = st;
        REQ_ADDR  = a;
        REQ_DATA  = d;
        REQ_TAG   = t;
        ok        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (REQ_READY) begin
                ok = 1'b1;
                break;
            end
            @(negedge ACLK);
        end
        if (ok) begin
            if (st) mdl_mem[a[9:2]] = d;
            e.tag  = t;
            e.data = mdl_mem[a[9:2]];
            exp_q.push_back(e);
            @(negedge ACLK);
        end else begin
            chk("req_accept_timeout", 64'(0), 64'(1));
        end
        REQ_VALID = 1'b0;
    endtask

    task automatic drain();
        res_hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !RES_VALID) break;
            @(negedge ACLK);
        end
        chk("drain", 64'(exp_q.size()), 64'(0));
        @(negedge ACLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          n0;
        logic [31:0] a;
        checks     = 0;
        errors     = 0;
        nres       = 0;
        lat        = 3;
        cache_hold = 1'b0;
        res_hold   = 1'b0;
        rand_bp    = 1'b0;
        REQ_VALID  = 1'b0;
        REQ_STORE  = 1'b0;
        REQ_ADDR   = '0;
        REQ_DATA   = '0;
        REQ_TAG    = '0;
        for (int i = 0; i < 256; i++) begin
            mdl_mem[i] = '0;
            cmem[i]    = '0;
        end
        mdl_mem[16]  = 32'hDEADBEEF;  cmem[16]  = 32'hDEADBEEF;
        mdl_mem[128] = 32'hCAFEF00D;  cmem[128] = 32'hCAFEF00D;
        mdl_mem[129] = 32'h0BADF00D;  cmem[129] = 32'h0BADF00D;
        ARESETN = 1'b1;
        #1 ARESETN = 1'b0;

        // Reset state
        repeat (3) @(negedge ACLK);
        chk("rst_req_ready", 64'(REQ_READY), 64'(0));
        chk("rst_res_valid", 64'(RES_VALID), 64'(0));
        chk("rst_cav", 64'(CACHE_ADDR_VALID), 64'(0));
        chk("rst_send_ready", 64'(CACHE_SEND_READY), 64'(0));
        #1 ARESETN = 1'b1;
        @(negedge ACLK);
        chk("req_ready_after_reset", 64'(REQ_READY), 64'(1));

        // Single load: address valid one cycle after acceptance, load flagged as no data
        push(1'b0, 32'h0000_0040, 32'h0, 8'h05, ok);
        chk("load_accept", 64'(ok), 64'(1));
        chk("cav_not_yet", 64'(CACHE_ADDR_VALID), 64'(0));
        @(negedge ACLK);
        chk("cav_issue", 64'(CACHE_ADDR_VALID), 64'(1));
        chk("cdv_load", 64'(CACHE_DATA_VALID), 64'(0));
        chk("cache_addr", 64'(CACHE_ADDR), 64'h40);
        drain();

        // Store then load of the same address
        push(1'b1, 32'h0000_0100, 32'h1234_5678, 8'h01, ok);
        push(1'b0, 32'h0000_0100, 32'h0, 8'h02, ok);
        drain();

        // FIFO full with the cache stalled
        cache_hold = 1'b1;
        @(negedge ACLK);
        n0 = nres;
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 32'h0000_0300 + 32'(i * 4), 32'h0, 8'(8'h10 + i), ok);
            chk("full_accept", 64'(ok), 64'(1));
        end
        @(negedge ACLK);
        chk("req_ready_full", 64'(REQ_READY), 64'(0));
        chk("cav_stalled", 64'(CACHE_ADDR_VALID), 64'(1));
        chk("cache_addr_stalled", 64'(CACHE_ADDR), 64'h300);
        cache_hold = 1'b0;
        drain();
        chk("full_count", 64'(nres - n0), 64'(5));

        // Result backpressure
        lat      = 1;
        res_hold = 1'b1;
        push(1'b0, 32'h0000_0200, 32'h0, 8'h20, ok);
        push(1'b0, 32'h0000_0204, 32'h0, 8'h21, ok);
        for (int i = 0; i < 50; i++) begin
            if (RES_VALID) break;
            @(negedge ACLK);
        end
        chk("bp_res_valid", 64'(RES_VALID), 64'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            chk("bp_hold_valid", 64'(RES_VALID), 64'(1));
            chk("bp_hold_tag", 64'(RES_TAG), 64'h20);
            chk("bp_hold_data", 64'(RES_DATA), 64'hCAFEF00D);
            chk("bp_no_issue", 64'(CACHE_ADDR_VALID), 64'(0));
        end
        res_hold = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (RES_READY) break;
            @(negedge ACLK);
            #1;
        end
        @(negedge ACLK);
        chk("bp_next_issue", 64'(CACHE_ADDR_VALID), 64'(1));
        chk("bp_next_addr", 64'(CACHE_ADDR), 64'h204);
        chk("bp_res_dropped", 64'(RES_VALID), 64'(0));
        drain();

        // Reset during WAIT with requests queued
        lat = 20;
        push(1'b0, 32'h0000_0040, 32'h0, 8'h30, ok);
        push(1'b0, 32'h0000_0200, 32'h0, 8'h31, ok);
        push(1'b0, 32'h0000_0204, 32'h0, 8'h32, ok);
        for (int i = 0; i < 50; i++) begin
            if (CACHE_SEND_READY) break;
            @(negedge ACLK);
        end
        chk("mid_in_wait", 64'(CACHE_SEND_READY), 64'(1));
        #1 ARESETN = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_req_ready", 64'(REQ_READY), 64'(0));
        chk("mid_cav", 64'(CACHE_ADDR_VALID), 64'(0));
        chk("mid_cdv", 64'(CACHE_DATA_VALID), 64'(0));
        chk("mid_send_ready", 64'(CACHE_SEND_READY), 64'(0));
        chk("mid_res_valid", 64'(RES_VALID), 64'(0));
        chk("mid_res_data", 64'(RES_DATA), 64'(0));
        chk("mid_res_tag", 64'(RES_TAG), 64'(0));
        chk("mid_cache_addr", 64'(CACHE_ADDR), 64'(0));
        repeat (2) @(negedge ACLK);
        #1 ARESETN = 1'b1;
        @(negedge ACLK);
        chk("mid_req_ready_after", 64'(REQ_READY), 64'(1));
        repeat (30) @(negedge ACLK);
        chk("mid_no_stale_res", 64'(RES_VALID), 64'(0));
        chk("mid_no_stale_issue", 64'(CACHE_ADDR_VALID), 64'(0));

        // Random loads/stores over a small address window
        n0      = nres;
        rand_bp = 1'b1;
        for (int i = 0; i < 100; i++) begin
            lat = $urandom_range(0, 2);
            a   = 32'h0000_1000 + 32'($urandom_range(0, 7) * 4);
            push(1'($urandom_range(0, 1)), a, $urandom, 8'(8'h40 + i), ok);
        end
        drain();
        rand_bp = 1'b0;
        drain();
        chk("rand_count", 64'(nres - n0), 64'(100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
